// File: rtl/wfunc_mult_sched_if.sv
// Stream-side handshake bundle between the window-function sequencer and its neighbours:
// sample input, coefficient ROM address, multiplier enable and the aligned output flags.
interface wfunc_mult_sched_if #(
  parameter int unsigned ADDR_W = 10
) ();
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [ADDR_W-1:0] coef_addr;
  logic              mult_en;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;

  modport master (
    output s_valid, s_last, m_ready,
    input  s_ready, coef_addr, mult_en, m_valid, m_last
  );

  modport slave (
    input  s_valid, s_last, m_ready,
    output s_ready, coef_addr, mult_en, m_valid, m_last
  );
endinterface

// File: rtl/wfunc_mult_sched.sv
// Sequencer for the window-function complex multiplier: coefficient addressing, frame-length
// checking, a valid/last shadow pipeline matched to the multiplier, and stop/drain control.
module wfunc_mult_sched #(
  parameter int unsigned PIPE_NUM = 10,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_en,
  input  logic [ADDR_W-1:0] cfg_len_m1,
  wfunc_mult_sched_if.slave bus,
  output logic              busy,
  output logic              err_short,
  output logic              err_long,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [PIPE_NUM-1:0] v_pipe_q, v_pipe_d;
  logic [PIPE_NUM-1:0] l_pipe_q, l_pipe_d;
  logic                err_short_q, err_short_d;
  logic                err_long_q, err_long_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;

  logic                stall;
  logic                s_ready;
  logic                acc;
  logic                out_hs;
  logic [ADDR_W-1:0]   len_eff;
  logic                at_end;

  assign stall   = v_pipe_q[PIPE_NUM-1] & ~bus.m_ready;
  assign s_ready = ~stall & (state_q == RUN);
  assign acc     = bus.s_valid & s_ready;
  assign out_hs  = v_pipe_q[PIPE_NUM-1] & bus.m_ready;

  // The first beat of a frame checks against the live config, later beats against the latch.
  assign len_eff = (idx_q == '0) ? cfg_len_m1 : len_q;
  assign at_end  = (idx_q == len_eff);

  always_comb begin
    idx_d       = idx_q;
    len_d       = len_q;
    err_short_d = err_short_q;
    err_long_d  = err_long_q;
    if (acc) begin
      if (idx_q == '0) len_d = cfg_len_m1;
      if (bus.s_last && (idx_q < len_eff)) err_short_d = 1'b1;
      if (!bus.s_last && at_end)           err_long_d  = 1'b1;
      idx_d = (bus.s_last || at_end) ? '0 : idx_q + ADDR_W'(1);
    end
  end

  always_comb begin
    v_pipe_d = v_pipe_q;
    l_pipe_d = l_pipe_q;
    if (!stall) begin
      v_pipe_d[0] = acc;
      l_pipe_d[0] = acc & bus.s_last;
      for (int unsigned i = 1; i < PIPE_NUM; i++) begin
        v_pipe_d[i] = v_pipe_q[i-1];
        l_pipe_d[i] = l_pipe_q[i-1];
      end
    end
    frame_cnt_d = frame_cnt_q + 16'(out_hs & l_pipe_q[PIPE_NUM-1]);
  end

  // DRAIN exits on the pipeline contents after this edge, so IDLE coincides with the last pop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (ctrl_en) state_d = RUN;
      RUN:   if ((idx_q == '0) && !acc && !ctrl_en) state_d = DRAIN;
      DRAIN: begin
        if (ctrl_en)              state_d = RUN;
        else if (v_pipe_d == '0)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      v_pipe_q    <= '0;
      l_pipe_q    <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      v_pipe_q    <= v_pipe_d;
      l_pipe_q    <= l_pipe_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.s_ready   = s_ready;
  assign bus.coef_addr = idx_q;
  assign bus.mult_en   = ~stall;
  assign bus.m_valid   = v_pipe_q[PIPE_NUM-1];
  assign bus.m_last    = l_pipe_q[PIPE_NUM-1];
  assign busy          = (state_q != IDLE) | (|v_pipe_q);
  assign err_short     = err_short_q;
  assign err_long      = err_long_q;
  assign frame_cnt     = frame_cnt_q;

endmodule
